// File: rtl/kraken_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : kraken_pkg
//  Description : Shared defaults, derived field widths and the refill-FSM
//                state type for the instruction cache responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package kraken_pkg;

    localparam int unsigned c_def_lines      = 16;
    localparam int unsigned c_def_words      = 4;
    localparam logic [31:0] c_def_text_base  = 32'h0000_0000;
    localparam logic [31:0] c_def_text_limit = 32'h0001_0000;

    // Byte offset within a 32-bit word is always two bits.
    localparam int unsigned c_byte_w     = 2;
    localparam int unsigned c_def_word_w = $clog2(c_def_words);
    localparam int unsigned c_def_idx_w  = $clog2(c_def_lines);
    localparam int unsigned c_def_tag_w  = 32 - c_byte_w - c_def_word_w - c_def_idx_w;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2
    } icache_state_t;

endpackage
`default_nettype wire

// File: rtl/icache_array.sv
`default_nettype none
// ============================================================================
//  Module      : icache_array
//  Description : Tag, valid and data storage for a direct-mapped I-cache.
//                Ports: clk/rst; combinational read (i_rd_idx, i_rd_word ->
//                o_rd_tag, o_rd_valid, o_rd_data); one word write port
//                (i_wr_*); tag write with optional valid set (i_tag_wr,
//                i_tag, i_set_valid) sharing i_wr_idx; global i_inv.
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_array #(
    parameter int unsigned LINES = 16,
    parameter int unsigned WORDS = 4,
    parameter int unsigned TAG_W = 24,
    localparam int unsigned C_IDX_W  = $clog2(LINES),
    localparam int unsigned C_WORD_W = $clog2(WORDS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [C_IDX_W-1:0]  i_rd_idx,
    input  logic [C_WORD_W-1:0] i_rd_word,
    output logic [TAG_W-1:0]    o_rd_tag,
    output logic                o_rd_valid,
    output logic [31:0]         o_rd_data,
    input  logic                i_wr_en,
    input  logic [C_IDX_W-1:0]  i_wr_idx,
    input  logic [C_WORD_W-1:0] i_wr_word,
    input  logic [31:0]         i_wr_data,
    input  logic                i_tag_wr,
    input  logic [TAG_W-1:0]    i_tag,
    input  logic                i_set_valid,
    input  logic                i_inv
);

    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [31:0]      r_data [LINES][WORDS];

    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx][i_rd_word];

    // Invalidate wins over a same-cycle valid set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_inv) begin
            r_valid <= '0;
        end else if (i_tag_wr && i_set_valid) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    // Payload storage carries no reset; the valid bits guard it.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_data[i_wr_idx][i_wr_word] <= i_wr_data;
        end
        if (i_tag_wr) begin
            r_tag[i_wr_idx] <= i_tag;
        end
    end

endmodule
`default_nettype wire

// File: rtl/icache_resp.sv
`default_nettype none
// ============================================================================
//  Module      : icache_resp
//  Description : Instruction-side responder. Looks up i_addr when i_rd is
//                high and returns i_data/i_miss/i_segfault one cycle later.
//                Misses start a single background line refill over the
//                mem_rd/mem_addr/mem_gnt/mem_rvalid/mem_rdata interface;
//                busy flags a refill in progress; inv clears all lines.
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_resp
    import kraken_pkg::*;
#(
    parameter int unsigned LINES      = c_def_lines,
    parameter int unsigned WORDS      = c_def_words,
    parameter logic [31:0] TEXT_BASE  = c_def_text_base,
    parameter logic [31:0] TEXT_LIMIT = c_def_text_limit
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_addr,
    input  logic        i_rd,
    input  logic        inv,
    output logic [31:0] i_data,
    output logic        i_miss,
    output logic        i_segfault,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam int unsigned c_word_w = $clog2(WORDS);
    localparam int unsigned c_idx_w  = $clog2(LINES);
    localparam int unsigned c_off_w  = c_byte_w + c_word_w;
    localparam int unsigned c_tag_w  = 32 - c_off_w - c_idx_w;

    icache_state_t       r_state;
    icache_state_t       w_next_state;
    logic [c_tag_w-1:0]  r_fill_tag;
    logic [c_idx_w-1:0]  r_fill_idx;
    logic [c_word_w-1:0] r_cnt;
    logic                r_drop;

    logic [c_word_w-1:0] w_word;
    logic [c_idx_w-1:0]  w_idx;
    logic [c_tag_w-1:0]  w_tag;
    logic [c_tag_w-1:0]  w_rd_tag;
    logic                w_rd_valid;
    logic [31:0]         w_rd_data;
    logic [32:0]         w_base_diff;
    logic [32:0]         w_limit_diff;
    logic                w_unused_bits;
    logic                w_seg;
    logic                w_stale;
    logic                w_hit;
    logic                w_miss;
    logic                w_last;
    logic                w_beat;

    assign w_word = i_addr[c_off_w-1:c_byte_w];
    assign w_idx  = i_addr[c_off_w+c_idx_w-1:c_off_w];
    assign w_tag  = i_addr[31:c_off_w+c_idx_w];

    // Range checks via the borrow of a 33-bit subtract so that a zero base
    // does not collapse into a constant comparison.
    assign w_base_diff   = {1'b0, i_addr} - {1'b0, TEXT_BASE};
    assign w_limit_diff  = {1'b0, i_addr} - {1'b0, TEXT_LIMIT};
    assign w_unused_bits = ^{w_base_diff[31:0], w_limit_diff[31:0]};
    assign w_seg = w_base_diff[32] || !w_limit_diff[32] || (i_addr[1:0] != 2'b00);

    // Words of the line being refilled below r_cnt already hold new data
    // while the old tag may still be valid; they must not be served.
    assign w_stale = (r_state == FILL) && (w_idx == r_fill_idx) && (w_word < r_cnt);
    assign w_hit   = w_rd_valid && (w_rd_tag == w_tag) && !w_stale;
    assign w_miss  = i_rd && !w_seg && !w_hit;

    assign w_last = (r_cnt == c_word_w'(WORDS - 1));
    assign w_beat = (r_state == FILL) && mem_rvalid;

    icache_array #(
        .LINES (LINES),
        .WORDS (WORDS),
        .TAG_W (c_tag_w)
    ) u_array (
        .clk         (clk),
        .rst         (rst),
        .i_rd_idx    (w_idx),
        .i_rd_word   (w_word),
        .o_rd_tag    (w_rd_tag),
        .o_rd_valid  (w_rd_valid),
        .o_rd_data   (w_rd_data),
        .i_wr_en     (w_beat),
        .i_wr_idx    (r_fill_idx),
        .i_wr_word   (r_cnt),
        .i_wr_data   (mem_rdata),
        .i_tag_wr    (w_beat && w_last),
        .i_tag       (r_fill_tag),
        .i_set_valid (!r_drop),
        .i_inv       (inv)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_miss)               w_next_state = REQ;
            REQ:     if (mem_gnt)              w_next_state = FILL;
            FILL:    if (mem_rvalid && w_last) w_next_state = IDLE;
            default:                           w_next_state = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        mem_rd   = (r_state == REQ);
        busy     = (r_state != IDLE);
        mem_addr = {r_fill_tag, r_fill_idx, {c_off_w{1'b0}}};
    end

    // Refill bookkeeping: latched line, beat counter and drop flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fill_tag <= '0;
            r_fill_idx <= '0;
            r_cnt      <= '0;
            r_drop     <= 1'b0;
        end else begin
            if (r_state == IDLE && w_miss) begin
                r_fill_tag <= w_tag;
                r_fill_idx <= w_idx;
                r_drop     <= 1'b0;
            end else if (inv && r_state != IDLE) begin
                r_drop <= 1'b1;
            end
            if (r_state == REQ && mem_gnt) begin
                r_cnt <= '0;
            end else if (w_beat) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Response registers; i_data only changes on a hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_data     <= '0;
            i_miss     <= 1'b0;
            i_segfault <= 1'b0;
        end else begin
            i_miss     <= w_miss;
            i_segfault <= i_rd && w_seg;
            if (i_rd && !w_seg && w_hit) begin
                i_data <= w_rd_data;
            end
        end
    end

endmodule
`default_nettype wire
